// File: rtl/cmd_script_seq.sv
// rtl/cmd_script_seq.sv - self-test command-script sequencer with per-phase watchdogs
// Optional: SEQ_CONT_ON_MISMATCH_EN keeps the script running after a response mismatch.
module cmd_script_seq #(
    parameter int DEPTH   = 32,
    parameter int CMD_W   = 16,
    parameter int RESP_W  = 8,
    parameter int SENT_TO = 60000,
    parameter int RESP_TO = 6000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [CMD_W+RESP_W+1:0]  wr_data,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   len,
    output logic [CMD_W-1:0]         cmd,
    output logic                     send_cmd,
    input  logic                     cmd_sent,
    input  logic                     resp_rdy,
    input  logic [RESP_W-1:0]        resp,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [$clog2(DEPTH)-1:0] err_idx,
    output logic [7:0]               err_cnt,
    output logic [RESP_W-1:0]        last_resp
);
    localparam int AW     = $clog2(DEPTH);
    localparam int EW     = CMD_W + RESP_W + 2;
    localparam int WD_MAX = (SENT_TO > RESP_TO) ? SENT_TO : RESP_TO;
    localparam int WD_W   = $clog2(WD_MAX);
    localparam logic [WD_W-1:0] SENT_LIM = WD_W'(SENT_TO - 1);
    localparam logic [WD_W-1:0] RESP_LIM = WD_W'(RESP_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SEND, S_WAIT_SENT, S_WAIT_RESP, S_NEXT, S_DONE, S_HALT
    } state_t;

    state_t              state, next_state;
    logic [EW-1:0]       mem [DEPTH];
    logic [AW-1:0]       idx;
    logic [AW:0]         len_q;
    logic [AW:0]         idx_inc;
    logic [RESP_W-1:0]   exp_q;
    logic [1:0]          rcnt;
    logic [WD_W-1:0]     wd;
    logic                wd_run, last_entry;
    logic                sent_ev, sent_to, resp_ev, resp_to, mism, halt_mism;

    assign idx_inc    = {1'b0, idx} + {{AW{1'b0}}, 1'b1};
    assign last_entry = (idx_inc == len_q);

    // Handshakes outside their own wait state fall through these gates and are ignored.
    assign sent_ev = (state == S_WAIT_SENT) && cmd_sent;
    assign sent_to = (state == S_WAIT_SENT) && !cmd_sent && (wd == SENT_LIM);
    assign resp_ev = (state == S_WAIT_RESP) && resp_rdy;
    assign resp_to = (state == S_WAIT_RESP) && !resp_rdy && (wd == RESP_LIM);
    assign mism    = resp_ev && (resp != exp_q);

`ifdef SEQ_CONT_ON_MISMATCH_EN
    assign halt_mism = 1'b0;
`else
    assign halt_mism = mism;
`endif

    // Watchdog is zero on entry to SEND and restarts on every accepted handshake.
    assign wd_run = (state == S_SEND) ||
                    ((state == S_WAIT_SENT) && !cmd_sent) ||
                    ((state == S_WAIT_RESP) && !resp_rdy);

    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (start) next_state = (len == '0) ? S_DONE : S_FETCH;
            S_FETCH:     next_state = S_SEND;
            S_SEND:      next_state = S_WAIT_SENT;
            S_WAIT_SENT: begin
                if (sent_ev)      next_state = (rcnt == 2'd0) ? S_NEXT : S_WAIT_RESP;
                else if (sent_to) next_state = S_HALT;
            end
            S_WAIT_RESP: begin
                if (resp_ev) begin
                    if (halt_mism)          next_state = S_HALT;
                    else if (rcnt == 2'd1)  next_state = S_NEXT;
                end else if (resp_to) begin
                    next_state = S_HALT;
                end
            end
            S_NEXT:      next_state = last_entry ? S_DONE : S_FETCH;
            S_DONE:      next_state = S_IDLE;
            S_HALT:      next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    always_comb begin
        send_cmd = (state == S_SEND);
        busy     = !(state inside {S_IDLE, S_DONE, S_HALT});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd       <= '0;
            exp_q     <= '0;
            rcnt      <= '0;
            idx       <= '0;
            len_q     <= '0;
            wd        <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            err_idx   <= '0;
            err_cnt   <= 8'd0;
            last_resp <= '0;
        end else begin
            wd <= wd_run ? wd + WD_W'(1) : '0;
            if (state == S_IDLE && start) begin
                len_q    <= len;
                idx      <= '0;
                done     <= 1'b0;
                err      <= 1'b0;
                err_code <= 2'd0;
                err_idx  <= '0;
                err_cnt  <= 8'd0;
            end
            if (state == S_FETCH) begin
                {rcnt, exp_q, cmd} <= mem[idx];
            end
            if (state == S_NEXT && !last_entry) begin
                idx <= idx + AW'(1);
            end
            if (resp_ev) begin
                last_resp <= resp;
                rcnt      <= rcnt - 2'd1;
            end
            // Only the first recorded error owns err_code / err_idx.
            if (mism) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                if (err_code == 2'd0) begin
                    err_code <= 2'd3;
                    err_idx  <= idx;
                end
            end
            if (sent_to || resp_to) begin
                err <= 1'b1;
                if (err_code == 2'd0) begin
                    err_code <= sent_to ? 2'd1 : 2'd2;
                    err_idx  <= idx;
                end
            end
            if (next_state == S_DONE) begin
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cmd_script_seq.sv
// tb/tb_cmd_script_seq.sv - directed self-checking bench for cmd_script_seq
module tb_cmd_script_seq;
    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int SENT_TO = 100;
    localparam int RESP_TO = 1200;

    logic          clk = 1'b0;
    logic          rst_n, wr_en, start, cmd_sent, resp_rdy;
    logic [AW-1:0] wr_addr;
    logic [25:0]   wr_data;
    logic [AW:0]   len;
    logic [7:0]    resp;
    logic [15:0]   cmd;
    logic          send_cmd, busy, done, err;
    logic [1:0]    err_code;
    logic [AW-1:0] err_idx;
    logic [7:0]    err_cnt, last_resp;
    logic [40:0]   outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign outs = {cmd, send_cmd, busy, done, err, err_code, err_idx, err_cnt, last_resp};

    cmd_script_seq #(
        .DEPTH(DEPTH), .CMD_W(16), .RESP_W(8), .SENT_TO(SENT_TO), .RESP_TO(RESP_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len), .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
        .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .err_idx(err_idx), .err_cnt(err_cnt), .last_resp(last_resp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [AW-1:0] a, input logic [15:0] c,
                               input logic [7:0] e, input logic [1:0] n);
        wr_en = 1'b1; wr_addr = a; wr_data = {n, e, c};
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW:0] l);
        start = 1'b1; len = l;
        step();
        start = 1'b0;
    endtask

    // Waits (bounded) for send_cmd, then acknowledges and returns nresp responses.
    task automatic serve(input logic [7:0] r, input int nresp,
                         output bit seen, output logic [15:0] seen_cmd);
        int n;
        seen = 1'b0; seen_cmd = '0; n = 0;
        while (!send_cmd && n < 20) begin
            step();
            n++;
        end
        if (send_cmd) begin
            seen = 1'b1; seen_cmd = cmd;
            step();
            cmd_sent = 1'b1; step(); cmd_sent = 1'b0;
            for (int i = 0; i < nresp; i++) begin
                resp = r; resp_rdy = 1'b1; step(); resp_rdy = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (outs !== 41'd0) begin errors++; $display("FAIL reset_outs got %h exp 0", outs); end
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_single();
        write_entry(0, 16'h2000, 8'hA5, 2'd1);
        pulse_start(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        checks++; if (send_cmd !== 1'b0) begin errors++; $display("FAIL single_early_send got %b exp 0", send_cmd); end
        step();
        checks++; if (send_cmd !== 1'b1) begin errors++; $display("FAIL single_send got %b exp 1", send_cmd); end
        checks++; if (cmd !== 16'h2000) begin errors++; $display("FAIL single_cmd got %h exp 2000", cmd); end
        step();
        checks++; if (send_cmd !== 1'b0) begin errors++; $display("FAIL single_send_width got %b exp 0", send_cmd); end
        cmd_sent = 1'b1; step(); cmd_sent = 1'b0;
        resp = 8'hA5; resp_rdy = 1'b1; step(); resp_rdy = 1'b0;
        step();
        checks++; if ({done, err, busy} !== 3'b100) begin errors++; $display("FAIL single_done got %b exp 100", {done, err, busy}); end
        checks++; if (last_resp !== 8'hA5) begin errors++; $display("FAIL single_last_resp got %h exp a5", last_resp); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done_hold got %b exp 1", done); end
    endtask

    task automatic test_two_resp();
        int drops;
        drops = 0;
        write_entry(0, 16'h4000, 8'h5A, 2'd2);
        pulse_start(1);
        step(); step();
        cmd_sent = 1'b1; step(); cmd_sent = 1'b0;
        resp = 8'h5A; resp_rdy = 1'b1; step(); resp_rdy = 1'b0;
        for (int i = 0; i < 999; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) drops++;
            step();
        end
        checks++; if (drops !== 0) begin errors++; $display("FAIL two_resp_busy drops %0d exp 0", drops); end
        resp_rdy = 1'b1; step(); resp_rdy = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL two_resp_early_done got %b exp 0", done); end
        step();
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL two_resp_done got %b exp 10", {done, err}); end
        step();
    endtask

    task automatic test_sent_timeout();
        write_entry(0, 16'h2100, 8'h00, 2'd1);
        pulse_start(1);
        repeat (100) step();
        checks++; if ({err, busy} !== 2'b01) begin errors++; $display("FAIL sent_to_early got %b exp 01", {err, busy}); end
        step();
        checks++; if ({err, err_code, err_idx, busy} !== {1'b1, 2'd1, 3'd0, 1'b0}) begin
            errors++; $display("FAIL sent_to got err=%b code=%0d idx=%0d busy=%b exp 1 1 0 0", err, err_code, err_idx, busy);
        end
        step();
    endtask

    task automatic test_resp_boundary();
        write_entry(0, 16'h2200, 8'h77, 2'd1);
        pulse_start(1);
        step(); step();
        cmd_sent = 1'b1; step(); cmd_sent = 1'b0;
        repeat (RESP_TO - 1) step();
        resp = 8'h77; resp_rdy = 1'b1; step(); resp_rdy = 1'b0;
        step();
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL resp_edge got %b exp 10", {done, err}); end
        step();
        pulse_start(1);
        step(); step();
        cmd_sent = 1'b1; step(); cmd_sent = 1'b0;
        repeat (RESP_TO - 1) step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL resp_to_early got %b exp 0", err); end
        step();
        checks++; if ({err, err_code, busy} !== {1'b1, 2'd2, 1'b0}) begin
            errors++; $display("FAIL resp_to got err=%b code=%0d busy=%b exp 1 2 0", err, err_code, busy);
        end
        step();
    endtask

    task automatic test_mismatch();
        bit s0, s1, s2;
        logic [15:0] c0, c1, c2;
        write_entry(0, 16'h1000, 8'hA5, 2'd1);
        write_entry(1, 16'h1001, 8'hA5, 2'd1);
        write_entry(2, 16'h1002, 8'hA5, 2'd1);
        pulse_start(3);
        serve(8'hA5, 1, s0, c0);
        serve(8'h00, 1, s1, c1);
        serve(8'hA5, 1, s2, c2);
        checks++; if (c1 !== 16'h1001) begin errors++; $display("FAIL mism_cmd1 got %h exp 1001", c1); end
`ifdef SEQ_CONT_ON_MISMATCH_EN
        step();
        checks++; if (s2 !== 1'b1 || c2 !== 16'h1002) begin errors++; $display("FAIL mism_entry2 seen=%b cmd=%h exp 1 1002", s2, c2); end
        checks++; if ({done, err, err_cnt} !== {1'b1, 1'b1, 8'd1}) begin
            errors++; $display("FAIL mism_cont got done=%b err=%b cnt=%0d exp 1 1 1", done, err, err_cnt);
        end
        step();
`else
        checks++; if (s2 !== 1'b0) begin errors++; $display("FAIL mism_entry2 seen=%b exp 0", s2); end
        checks++; if ({done, err, err_cnt, busy} !== {1'b0, 1'b1, 8'd1, 1'b0}) begin
            errors++; $display("FAIL mism_halt got done=%b err=%b cnt=%0d busy=%b exp 0 1 1 0", done, err, err_cnt, busy);
        end
`endif
        checks++; if ({err_code, err_idx} !== {2'd3, 3'd1}) begin
            errors++; $display("FAIL mism_code got code=%0d idx=%0d exp 3 1", err_code, err_idx);
        end
    endtask

    task automatic test_back_to_back();
        bit s;
        logic [15:0] c;
        int n;
        write_entry(0, 16'h1111, 8'h11, 2'd1);
        write_entry(1, 16'h2222, 8'h22, 2'd1);
        pulse_start(2);
        serve(8'h11, 1, s, c);
        n = 1;
        while (!send_cmd && n < 10) begin
            step();
            n++;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_gap got %0d exp 3", n); end
        checks++; if (cmd !== 16'h2222) begin errors++; $display("FAIL b2b_cmd got %h exp 2222", cmd); end
        serve(8'h22, 1, s, c);
        step();
        checks++; if ({done, err, err_cnt} !== {1'b1, 1'b0, 8'd0}) begin
            errors++; $display("FAIL b2b_done got done=%b err=%b cnt=%0d exp 1 0 0", done, err, err_cnt);
        end
        step();
    endtask

    task automatic test_len_zero();
        pulse_start(0);
        checks++; if ({done, busy, send_cmd} !== 3'b100) begin
            errors++; $display("FAIL len0 got %b exp 100", {done, busy, send_cmd});
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit s;
        logic [15:0] c;
        write_entry(0, 16'h3000, 8'h3C, 2'd1);
        pulse_start(1);
        step(); step();
        cmd_sent = 1'b1; step(); cmd_sent = 1'b0;
        rst_n = 1'b0;
        step();
        checks++; if (outs !== 41'd0) begin errors++; $display("FAIL mid_reset_outs got %h exp 0", outs); end
        rst_n = 1'b1;
        step();
        pulse_start(1);
        serve(8'h3C, 1, s, c);
        checks++; if (c !== 16'h3000) begin errors++; $display("FAIL mid_reset_mem got %h exp 3000", c); end
        step();
        checks++; if ({done, err, last_resp} !== {1'b1, 1'b0, 8'h3C}) begin
            errors++; $display("FAIL mid_reset_rerun got done=%b err=%b last=%h exp 1 0 3c", done, err, last_resp);
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; cmd_sent = 1'b0; resp_rdy = 1'b0;
        wr_addr = '0; wr_data = '0; len = '0; resp = '0;
        test_reset();
        test_single();
        test_two_resp();
        test_sent_timeout();
        test_resp_boundary();
        test_mismatch();
        test_back_to_back();
        test_len_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
